// File: rtl/mau_pkg.sv
// Shared types and constants for the memory access unit.
package mau_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  // One byte lane at offset 0; wider masks and other offsets derive from it.
  localparam logic [31:0] LANE_MASK = 32'h0000_00FF;

  // Encoding 3 is not a real size; treat it as a full word.
  function automatic size_e norm_size(input logic [1:0] s);
    return (s == 2'd3) ? SZ_WORD : size_e'(s);
  endfunction

  // Bit mask covering the lanes touched by an access of size sz at byte offset off.
  function automatic logic [31:0] lane_mask(input size_e sz, input logic [1:0] off);
    logic [31:0] m;
    case (sz)
      SZ_BYTE: m = LANE_MASK;
      SZ_HALF: m = LANE_MASK | (LANE_MASK << 8);
      default: m = '1;
    endcase
    return m << {off, 3'b000};
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational byte-lane steering: store merge (read-modify-write) and
// load extract with sign/zero extension. Little-endian lanes.
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] data_i,
  input  size_e       size_i,
  input  logic [1:0]  off_i,
  input  logic        unsigned_i,
  output logic [31:0] merged_o,
  output logic [31:0] extracted_o
);

  logic [31:0] mask;
  logic [31:0] data_sh;
  logic [31:0] word_sh;

  assign mask    = lane_mask(size_i, off_i);
  assign data_sh = data_i << {off_i, 3'b000};
  assign word_sh = old_word_i >> {off_i, 3'b000};

  // Replace only the addressed lanes of the old word.
  assign merged_o = (old_word_i & ~mask) | (data_sh & mask);

  // Move the addressed byte/half down to bit 0 and extend it.
  always_comb begin
    extracted_o = old_word_i;
    case (size_i)
      SZ_BYTE: extracted_o = {{24{word_sh[7] & ~unsigned_i}}, word_sh[7:0]};
      SZ_HALF: extracted_o = {{16{word_sh[15] & ~unsigned_i}}, word_sh[15:0]};
      default: extracted_o = old_word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-request load/store unit in front of a word-wide RAM with
// combinational read. Sub-word stores are done as read-modify-write.
// Optional feature macro: MAU_MISALIGN_CHECK_EN (reject misaligned half/word
// accesses with rsp_err); when undefined the offending low bits are ignored.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  state_e                state_q;
  logic                  we_q;
  size_e                 size_q;
  logic                  uns_q;
  logic [1:0]            off_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  mem_read_q, mem_write_q, rsp_valid_q;
`ifdef MAU_MISALIGN_CHECK_EN
  logic                  rsp_err_q;
`endif

  size_e                 size_d;
  logic [1:0]            off_d;
  logic                  reject_d;
  logic [DATA_WIDTH-1:0] merged, extracted;

  assign size_d = norm_size(req_size);

  // Effective lane offset: low bits below the access size are dropped, so a
  // misaligned access silently becomes the aligned one when not rejected.
  always_comb begin
    off_d = 2'b00;
    case (size_d)
      SZ_BYTE: off_d = req_addr[1:0];
      SZ_HALF: off_d = {req_addr[1], 1'b0};
      default: off_d = 2'b00;
    endcase
  end

  // Misalignment decision at accept time.
`ifdef MAU_MISALIGN_CHECK_EN
  assign reject_d = ((size_d == SZ_HALF) && req_addr[0]) ||
                    ((size_d == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign reject_d = 1'b0;
`endif

  mau_lane_align u_align (
    .old_word_i  (mem_rdata),
    .data_i      (wdata_q),
    .size_i      (size_q),
    .off_i       (off_q),
    .unsigned_i  (uns_q),
    .merged_o    (merged),
    .extracted_o (extracted)
  );

  // FSM with registered outputs: each strobe is set on entry to its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_rdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifdef MAU_MISALIGN_CHECK_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            size_q      <= size_d;
            uns_q       <= req_unsigned;
            off_q       <= off_d;
            wdata_q     <= req_wdata;
            mem_addr_q  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            rsp_rdata_q <= '0;
`ifdef MAU_MISALIGN_CHECK_EN
            rsp_err_q   <= reject_d;
`endif
            if (reject_d) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
            end else if (req_we && (size_d == SZ_WORD)) begin
              state_q     <= WRITE;
              mem_write_q <= 1'b1;
              mem_wdata_q <= req_wdata;
            end else begin
              state_q    <= READ;
              mem_read_q <= 1'b1;
            end
          end
        end
        READ: begin
          if (we_q) begin
            state_q     <= WRITE;
            mem_write_q <= 1'b1;
            mem_wdata_q <= merged;
          end else begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= extracted;
          end
        end
        WRITE: begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobes are masked by rst so a reset landing in WRITE never commits.
  assign req_ready = (state_q == IDLE) && !rst;
  assign mem_read  = mem_read_q  && !rst;
  assign mem_write = mem_write_q && !rst;
  assign rsp_valid = rsp_valid_q && !rst;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_rdata = rsp_rdata_q;
`ifdef MAU_MISALIGN_CHECK_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural RAM
// (combinational read, posedge write).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err, mem_read, mem_write;
  logic [31:0] rsp_rdata, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;

  logic [31:0] ram [0:255];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) ram[mem_addr[9:2]] <= mem_wdata;

  mem_access_unit #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Issue one request and watch it to completion, sampling on negedges.
  // lat = negedges after the accept edge until rsp_valid (0 = never seen).
  // bad counts read/write overlap or unaligned mem_addr while strobing.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [9:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int nrd, output int nwr, output logic [31:0] wdat,
                        output int bad);
    @(negedge clk);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; nrd = 0; nwr = 0; bad = 0; rd = 'x; er = 1'bx; wdat = 'x;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_read) nrd++;
      if (mem_write) begin nwr++; wdat = mem_wdata; end
      if (mem_read && mem_write) bad++;
      if ((mem_read || mem_write) && (mem_addr[1:0] != 2'b00)) bad++;
      if (rsp_valid) begin lat = k; rd = rsp_rdata; er = rsp_err; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b exp 0", req_ready); end
    tests++;
    if ({rsp_valid, rsp_err, mem_read, mem_write} !== 4'b0 ||
        mem_addr !== 10'd0 || mem_wdata !== 32'd0 || rsp_rdata !== 32'd0) begin
      fails++;
      $display("FAIL reset_outputs got v%b e%b r%b w%b a%h wd%h rd%h exp all 0",
               rsp_valid, rsp_err, mem_read, mem_write, mem_addr, mem_wdata, rsp_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL post_reset_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_word;
    int lat, nrd, nwr, bad; logic [31:0] rd, wdat; logic er;
    do_req(1'b1, 2'd2, 1'b0, 10'd0, 32'hDEADBEEF, lat, rd, er, nrd, nwr, wdat, bad);
    tests++;
    if (lat !== 2 || nwr !== 1 || nrd !== 0 || rd !== 32'd0 || er !== 1'b0 || bad !== 0) begin
      fails++;
      $display("FAIL sw_word got lat%0d nwr%0d nrd%0d rd%h er%b bad%0d exp lat2 nwr1 nrd0 rd0 er0 bad0",
               lat, nwr, nrd, rd, er, bad);
    end
    tests++;
    if (ram[0] !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_ram got %h exp deadbeef", ram[0]); end
    do_req(1'b0, 2'd2, 1'b0, 10'd0, 32'h0, lat, rd, er, nrd, nwr, wdat, bad);
    tests++;
    if (lat !== 2 || rd !== 32'hDEADBEEF || nrd !== 1 || nwr !== 0 || bad !== 0) begin
      fails++;
      $display("FAIL lw_word got lat%0d rd%h nrd%0d nwr%0d bad%0d exp lat2 rd deadbeef nrd1 nwr0",
               lat, rd, nrd, nwr, bad);
    end
  endtask

  task automatic test_subword_store;
    int lat, nrd, nwr, bad; logic [31:0] rd, wdat; logic er;
    do_req(1'b1, 2'd2, 1'b0, 10'd4, 32'hCAFEBABE, lat, rd, er, nrd, nwr, wdat, bad);
    do_req(1'b1, 2'd0, 1'b0, 10'd6, 32'h00000011, lat, rd, er, nrd, nwr, wdat, bad);
    tests++;
    if (lat !== 3 || nrd !== 1 || nwr !== 1 || wdat !== 32'hCA11BABE || bad !== 0) begin
      fails++;
      $display("FAIL sb_rmw got lat%0d nrd%0d nwr%0d wdata%h bad%0d exp lat3 nrd1 nwr1 ca11babe",
               lat, nrd, nwr, wdat, bad);
    end
    do_req(1'b0, 2'd2, 1'b0, 10'd4, 32'h0, lat, rd, er, nrd, nwr, wdat, bad);
    tests++;
    if (rd !== 32'hCA11BABE) begin fails++; $display("FAIL sb_readback got %h exp ca11babe", rd); end
    // Half stores, upper half then lower half, with junk above the half.
    do_req(1'b1, 2'd2, 1'b0, 10'd12, 32'h11223344, lat, rd, er, nrd, nwr, wdat, bad);
    do_req(1'b1, 2'd1, 1'b0, 10'd14, 32'hFFFFABCD, lat, rd, er, nrd, nwr, wdat, bad);
    tests++;
    if (lat !== 3 || wdat !== 32'hABCD3344) begin
      fails++; $display("FAIL sh_hi got lat%0d wdata%h exp lat3 abcd3344", lat, wdat);
    end
    do_req(1'b1, 2'd1, 1'b0, 10'd12, 32'h12345A5A, lat, rd, er, nrd, nwr, wdat, bad);
    tests++;
    if (ram[3] !== 32'hABCD5A5A) begin fails++; $display("FAIL sh_lo got %h exp abcd5a5a", ram[3]); end
    do_req(1'b1, 2'd0, 1'b0, 10'd12, 32'hFFFFFF22, lat, rd, er, nrd, nwr, wdat, bad);
    tests++;
    if (ram[3] !== 32'hABCD5A22) begin fails++; $display("FAIL sb_lane0 got %h exp abcd5a22", ram[3]); end
  endtask

  task automatic test_load_extract;
    int lat, nrd, nwr, bad; logic [31:0] rd, wdat; logic er;
    logic [1:0]  sz  [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
    logic        un  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [9:0]  ad  [8] = '{10'd9, 10'd11, 10'd11, 10'd10, 10'd10, 10'd10, 10'd8, 10'd8};
    logic [31:0] exp [8] = '{32'h0000007F, 32'h00000080, 32'hFFFFFF80, 32'hFFFFFFFF,
                             32'hFFFF80FF, 32'h000080FF, 32'h80FF7F01, 32'h80FF7F01};
    do_req(1'b1, 2'd2, 1'b0, 10'd8, 32'h80FF7F01, lat, rd, er, nrd, nwr, wdat, bad);
    for (int i = 0; i < 8; i++) begin
      do_req(1'b0, sz[i], un[i], ad[i], 32'h0, lat, rd, er, nrd, nwr, wdat, bad);
      tests++;
      if (lat !== 2 || rd !== exp[i] || nwr !== 0) begin
        fails++;
        $display("FAIL load_ext[%0d] got lat%0d rd%h nwr%0d exp lat2 rd%h nwr0", i, lat, rd, nwr, exp[i]);
      end
    end
  endtask

  task automatic test_misalign;
    int lat, nrd, nwr, bad; logic [31:0] rd, wdat; logic er;
    do_req(1'b0, 2'd2, 1'b0, 10'd2, 32'h0, lat, rd, er, nrd, nwr, wdat, bad);
    tests++;
`ifdef MAU_MISALIGN_CHECK_EN
    if (lat !== 1 || er !== 1'b1 || rd !== 32'd0 || nrd !== 0 || nwr !== 0) begin
      fails++;
      $display("FAIL mis_word got lat%0d er%b rd%h nrd%0d nwr%0d exp lat1 er1 rd0 nrd0 nwr0", lat, er, rd, nrd, nwr);
    end
`else
    if (lat !== 2 || er !== 1'b0 || rd !== 32'hDEADBEEF || nrd !== 1) begin
      fails++;
      $display("FAIL mis_word got lat%0d er%b rd%h nrd%0d exp lat2 er0 deadbeef nrd1", lat, er, rd, nrd);
    end
`endif
    do_req(1'b0, 2'd1, 1'b0, 10'd9, 32'h0, lat, rd, er, nrd, nwr, wdat, bad);
    tests++;
`ifdef MAU_MISALIGN_CHECK_EN
    if (lat !== 1 || er !== 1'b1 || rd !== 32'd0 || nrd !== 0) begin
      fails++; $display("FAIL mis_half got lat%0d er%b rd%h nrd%0d exp lat1 er1 rd0 nrd0", lat, er, rd, nrd);
    end
`else
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h00007F01) begin
      fails++; $display("FAIL mis_half got lat%0d er%b rd%h exp lat2 er0 00007f01", lat, er, rd);
    end
`endif
  endtask

  task automatic test_reset_mid;
    int lat, nrd, nwr, bad, nrsp, nwr2; logic [31:0] rd, wdat; logic er;
    do_req(1'b1, 2'd2, 1'b0, 10'd20, 32'h55667788, lat, rd, er, nrd, nwr, wdat, bad);
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 10'd20;
    req_wdata = 32'h99; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);               // READ
    @(negedge clk);               // WRITE
    tests++;
    if (mem_write !== 1'b1) begin fails++; $display("FAIL rmid_in_write got %b exp 1", mem_write); end
    rst = 1'b1;
    nrsp = 0; nwr2 = 0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid) nrsp++;
      if (mem_write) nwr2++;
      tests++;
      if (req_ready !== 1'b0) begin fails++; $display("FAIL rmid_ready_in_rst got %b exp 0", req_ready); end
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) nrsp++;
      if (mem_write) nwr2++;
    end
    tests++;
    if (nrsp !== 0 || nwr2 !== 0) begin
      fails++; $display("FAIL rmid_abort got rsp%0d wr%0d exp 0 0", nrsp, nwr2);
    end
    tests++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready_after got %b exp 1", req_ready); end
    tests++;
    if (ram[5] !== 32'h55667788) begin fails++; $display("FAIL rmid_ram got %h exp 55667788", ram[5]); end
  endtask

  task automatic test_back_to_back;
    int acc, nrsp, busy;
    int t [4];
    logic [31:0] r [4];
    acc = 0; nrsp = 0; busy = 0;
    @(negedge clk);
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 10'd8; req_wdata = '0;
    req_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      if (acc == 3) req_valid = 1'b0;
      if (req_valid && req_ready) acc++;
      if (rsp_valid && nrsp < 4) begin t[nrsp] = k; r[nrsp] = rsp_rdata; nrsp++; end
      if (!req_ready) busy++;
    end
    req_valid = 1'b0;
    tests++;
    if (nrsp !== 3) begin fails++; $display("FAIL b2b_count got %0d exp 3", nrsp); end
    else begin
      tests++;
      if (t[0] !== 2 || t[1] !== 5 || t[2] !== 8) begin
        fails++; $display("FAIL b2b_spacing got %0d %0d %0d exp 2 5 8", t[0], t[1], t[2]);
      end
      tests++;
      if (r[0] !== 32'h80FF7F01 || r[1] !== 32'h80FF7F01 || r[2] !== 32'h80FF7F01) begin
        fails++; $display("FAIL b2b_data got %h %h %h exp 80ff7f01", r[0], r[1], r[2]);
      end
    end
    tests++;
    if (busy !== 6) begin fails++; $display("FAIL b2b_busy_ready_low got %0d exp 6", busy); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword_store();
    test_load_extract();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
